// File: rtl/key_tx_bridge.sv
// key_tx_bridge: turns debounced PS/2 make codes into ASCII bytes, queues them
// in a small FIFO and feeds them to uart_tx one frame at a time.
module key_tx_bridge #(
    parameter int DEPTH         = 8,
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    input  logic       shift,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic [4:0] fifo_count,
    output logic       overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] STABLE_HIT = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [4:0]    DEPTH_C    = 5'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    // Set-2 make code to ASCII; bit 8 flags a mapped code.
    function automatic logic [8:0] f_translate(input logic [7:0] code, input logic shift_held);
        logic [7:0] letter_base;
        logic [8:0] result;
        letter_base = shift_held ? 8'h41 : 8'h61;
        result      = 9'h000;
        case (code)
            8'h1C: result = {1'b1, letter_base + 8'd0};
            8'h32: result = {1'b1, letter_base + 8'd1};
            8'h21: result = {1'b1, letter_base + 8'd2};
            8'h23: result = {1'b1, letter_base + 8'd3};
            8'h24: result = {1'b1, letter_base + 8'd4};
            8'h2B: result = {1'b1, letter_base + 8'd5};
            8'h34: result = {1'b1, letter_base + 8'd6};
            8'h33: result = {1'b1, letter_base + 8'd7};
            8'h43: result = {1'b1, letter_base + 8'd8};
            8'h3B: result = {1'b1, letter_base + 8'd9};
            8'h42: result = {1'b1, letter_base + 8'd10};
            8'h4B: result = {1'b1, letter_base + 8'd11};
            8'h3A: result = {1'b1, letter_base + 8'd12};
            8'h31: result = {1'b1, letter_base + 8'd13};
            8'h44: result = {1'b1, letter_base + 8'd14};
            8'h4D: result = {1'b1, letter_base + 8'd15};
            8'h15: result = {1'b1, letter_base + 8'd16};
            8'h2D: result = {1'b1, letter_base + 8'd17};
            8'h1B: result = {1'b1, letter_base + 8'd18};
            8'h2C: result = {1'b1, letter_base + 8'd19};
            8'h3C: result = {1'b1, letter_base + 8'd20};
            8'h2A: result = {1'b1, letter_base + 8'd21};
            8'h1D: result = {1'b1, letter_base + 8'd22};
            8'h22: result = {1'b1, letter_base + 8'd23};
            8'h35: result = {1'b1, letter_base + 8'd24};
            8'h1A: result = {1'b1, letter_base + 8'd25};
            8'h45: result = {1'b1, 8'h30};
            8'h16: result = {1'b1, 8'h31};
            8'h1E: result = {1'b1, 8'h32};
            8'h26: result = {1'b1, 8'h33};
            8'h25: result = {1'b1, 8'h34};
            8'h2E: result = {1'b1, 8'h35};
            8'h36: result = {1'b1, 8'h36};
            8'h3D: result = {1'b1, 8'h37};
            8'h3E: result = {1'b1, 8'h38};
            8'h46: result = {1'b1, 8'h39};
            8'h29: result = {1'b1, 8'h20};
            8'h5A: result = {1'b1, 8'h0D};
            default: result = 9'h000;
        endcase
        return result;
    endfunction

    logic [7:0]    r_key_s1, r_key_s2, r_key_prev, r_last_key;
    logic          r_shift_s1, r_shift_s2;
    logic [CW-1:0] r_stab_cnt;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [4:0]    r_count;
    logic          r_overflow;
    logic [7:0]    r_tx_data;
    state_t        r_state, w_next_state;

    logic          w_match, w_stable, w_accept, w_push, w_full, w_wr_en;
    logic [8:0]    w_xlat;
    logic          w_tx_wr, w_pop, w_load;

    // Two-flop synchronizers for the asynchronous keyboard inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_s1   <= 8'h00;
            r_key_s2   <= 8'h00;
            r_shift_s1 <= 1'b0;
            r_shift_s2 <= 1'b0;
        end else begin
            r_key_s1   <= key;
            r_key_s2   <= r_key_s1;
            r_shift_s1 <= shift;
            r_shift_s2 <= r_shift_s1;
        end
    end

    // The stable pulse fires once, on the cycle the held value completes its window.
    assign w_match  = (r_key_s2 == r_key_prev);
    assign w_stable = w_match && (r_stab_cnt == STABLE_HIT);
    assign w_xlat   = f_translate(r_key_s2, r_shift_s2);
    assign w_accept = w_stable && (r_key_s2 != 8'h00) && (r_key_s2 != r_last_key);
    assign w_push   = w_accept && w_xlat[8];

    // Stability counter (saturating) and last accepted/stable key tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_prev <= 8'h00;
            r_stab_cnt <= '0;
            r_last_key <= 8'h00;
        end else begin
            r_key_prev <= r_key_s2;
            if (!w_match) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != STABLE_MAX) begin
                r_stab_cnt <= r_stab_cnt + CNT_ONE;
            end
            if (w_stable) begin
                r_last_key <= r_key_s2;
            end
        end
    end

    // A full FIFO still accepts a push when the same cycle pops.
    assign w_full  = (r_count == DEPTH_C);
    assign w_wr_en = w_push && (!w_full || w_pop);

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_xlat[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 5'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // TX FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // TX FSM next state: never strobe into a transmitter that is still busy.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_count != 5'd0) && !tx_active) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD: w_next_state = S_BUSY;
            S_BUSY: begin
                if (tx_done) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_BUSY;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // TX FSM outputs: head byte latched on entry to LOAD, popped during LOAD.
    always_comb begin
        w_tx_wr = 1'b0;
        w_pop   = 1'b0;
        w_load  = 1'b0;
        case (r_state)
            S_IDLE: w_load = (w_next_state == S_LOAD);
            S_LOAD: begin
                w_tx_wr = 1'b1;
                w_pop   = 1'b1;
            end
            default: begin
                w_tx_wr = 1'b0;
                w_pop   = 1'b0;
            end
        endcase
    end

    // Transmit data register; holds until the next LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_data <= 8'h00;
        end else if (w_load) begin
            r_tx_data <= r_mem[r_rd_ptr];
        end
    end

    assign tx_wr      = w_tx_wr;
    assign tx_data    = r_tx_data;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
